sim_ctrl: RTL and testbench

Synthesizable simulation controller instantiated inside tb_top, below the top-level clock/reset generator. It sequences the DUT reset (power-on stretch), runs a kickable watchdog, and provides a small write-only mailbox. Through the mailbox the DUT reports exit status and streams console characters. It raises a sticky sim_done so both the iverilog and Verilator wrappers can end the run identically, without relying on a fixed cycle budget.

---
 rtl/sim_ctrl_pkg.sv | 18 +
 rtl/sim_ctrl_wdog.sv | 30 +++
 rtl/sim_ctrl.sv | 124 ++++++++++++
 tb/tb_sim_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation controller: state encoding,
// mailbox address map and the exit code reported on watchdog expiry.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_EXIT    = 2'd0;
    localparam logic [1:0] ADDR_KICK    = 2'd1;
    localparam logic [1:0] ADDR_PUTCHAR = 2'd2;

    localparam logic [7:0] EXIT_CODE_TIMEOUT = 8'hFF;

endpackage

// File: rtl/sim_ctrl_wdog.sv
// Loadable down-counter shared by the hold stretch, the watchdog and the drain
// timer. A count of zero never expires, so loading zero disables it.
module sim_ctrl_wdog #(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Expiry is the edge on which the count steps from 1 to 0; a load in the
    // same cycle takes priority and suppresses it.
    assign expired = en && !load && (cnt == CNT_W'(1));

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: stretches the DUT reset, runs a kickable watchdog and
// decodes a write-only mailbox for exit status and console characters.
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned DRAIN_CYCLES   = 8,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_addr,
    input  logic [31:0]      wr_data,
    output logic             sys_reset,
    output logic             char_valid,
    output logic [7:0]       char_data,
    output logic             sim_done,
    output logic             sim_pass,
    output logic [7:0]       exit_code,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("sim_ctrl: RESET_CYCLES must be >= 1");
    end
    if (CNT_W < 32) begin : g_width_chk
        if (((RESET_CYCLES | TIMEOUT_CYCLES | DRAIN_CYCLES) >> CNT_W) != 0) begin : g_bad_width
            $error("sim_ctrl: cycle parameters do not fit in CNT_W");
        end
    end

    state_e state, state_nx;
    logic   accept, do_exit, do_kick, do_put, time_out;
    logic   hold_exp, wd_exp, drain_exp;
    logic   unused_data;

    assign wr_ready  = (state == RUN);
    assign sys_reset = (state == HOLD);
    assign sim_done  = (state == DONE);

    assign accept   = wr_valid && wr_ready;
    assign do_exit  = accept && (wr_addr == ADDR_EXIT);
    assign do_kick  = accept && (wr_addr == ADDR_KICK);
    assign do_put   = accept && (wr_addr == ADDR_PUTCHAR);
    // An EXIT in the expiry cycle wins; a KICK already masks wd_exp via load.
    assign time_out = wd_exp && !do_exit;

    assign unused_data = ^wr_data[31:8];

    sim_ctrl_wdog #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(RESET_CYCLES))) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == HOLD),
        .expired  (hold_exp)
    );

    sim_ctrl_wdog #(.CNT_W(CNT_W)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_exp || do_kick),
        .load_val (CNT_W'(TIMEOUT_CYCLES)),
        .en       (state == RUN),
        .expired  (wd_exp)
    );

    sim_ctrl_wdog #(.CNT_W(CNT_W)) u_drain (
        .clk      (clk),
        .reset    (reset),
        .load     (do_exit || time_out),
        .load_val (CNT_W'(DRAIN_CYCLES)),
        .en       (state == DRAIN),
        .expired  (drain_exp)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= HOLD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            HOLD:    if (hold_exp) state_nx = RUN;
            RUN:     if (do_exit || time_out) state_nx = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_exp) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            char_valid  <= 1'b0;
            char_data   <= '0;
            sim_pass    <= 1'b0;
            exit_code   <= '0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
        end else begin
            char_valid <= do_put;
            if (do_put)
                char_data <= wr_data[7:0];
            if (do_exit) begin
                exit_code <= wr_data[7:0];
                sim_pass  <= (wr_data[7:0] == 8'd0);
            end else if (time_out) begin
                timed_out <= 1'b1;
                exit_code <= EXIT_CODE_TIMEOUT;
                sim_pass  <= 1'b0;
            end
            if ((state == RUN || state == DRAIN) && cycle_count != {CNT_W{1'b1}})
                cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sim_ctrl.sv
// Scoreboard bench for sim_ctrl: two configurations share one stimulus stream
// and are compared every cycle against a timestamp-based reference model.
module tb_sim_ctrl;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;

    always #5 clk = ~clk;

    logic        a_rdy, a_sr, a_cv, a_done, a_pass, a_tout;
    logic [7:0]  a_cd, a_code;
    logic [31:0] a_cc;
    logic        b_rdy, b_sr, b_cv, b_done, b_pass, b_tout;
    logic [7:0]  b_cd, b_code;
    logic [7:0]  b_cc;

    sim_ctrl #(.RESET_CYCLES(16), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(8), .CNT_W(32)) u_a (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(a_rdy), .wr_addr(wr_addr),
        .wr_data(wr_data), .sys_reset(a_sr), .char_valid(a_cv), .char_data(a_cd),
        .sim_done(a_done), .sim_pass(a_pass), .exit_code(a_code), .timed_out(a_tout),
        .cycle_count(a_cc)
    );

    sim_ctrl #(.RESET_CYCLES(3), .TIMEOUT_CYCLES(0), .DRAIN_CYCLES(0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(b_rdy), .wr_addr(wr_addr),
        .wr_data(wr_data), .sys_reset(b_sr), .char_valid(b_cv), .char_data(b_cd),
        .sim_done(b_done), .sim_pass(b_pass), .exit_code(b_code), .timed_out(b_tout),
        .cycle_count(b_cc)
    );

    typedef struct packed {
        logic        sr;
        logic        rdy;
        logic        cv;
        logic [7:0]  cd;
        logic        done;
        logic        pass;
        logic [7:0]  code;
        logic        tout;
        logic [31:0] cc;
    } obs_t;

    obs_t obs_a, obs_b;
    assign obs_a = {a_sr, a_rdy, a_cv, a_cd, a_done, a_pass, a_code, a_tout, a_cc};
    assign obs_b = {b_sr, b_rdy, b_cv, b_cd, b_done, b_pass, b_code, b_tout, 24'd0, b_cc};

    // Model: k = edges since reset released, rl = k at last watchdog reload,
    // endk = k at the exit/timeout edge (-1 while none).
    typedef struct {
        int         k;
        int         rl;
        int         endk;
        longint     cc;
        logic       cv;
        logic [7:0] cd;
        logic [7:0] code;
        logic       pass;
        logic       tout;
    } mdl_t;

    mdl_t   m[NI];
    int     rc[NI]   = '{16, 3};
    int     tc[NI]   = '{100, 0};
    int     dc[NI]   = '{8, 0};
    longint cmax[NI] = '{64'hFFFF_FFFF, 64'd255};

    obs_t exp_q0[$];
    obs_t exp_q1[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic in_run(int i);
        return (m[i].k >= rc[i]) && (m[i].endk < 0);
    endfunction

    function automatic logic in_done(int i);
        return (m[i].endk >= 0) && (m[i].k >= m[i].endk + dc[i]);
    endfunction

    task automatic model_edge(int i, logic r, logic v, logic [1:0] a, logic [31:0] d);
        logic run, drain;
        int   kn;
        if (r) begin
            m[i].k = 0; m[i].rl = 0; m[i].endk = -1; m[i].cc = 0; m[i].cv = 1'b0;
            m[i].cd = 8'd0; m[i].code = 8'd0; m[i].pass = 1'b0; m[i].tout = 1'b0;
            return;
        end
        run   = in_run(i);
        drain = (m[i].endk >= 0) && !in_done(i);
        kn    = m[i].k + 1;
        m[i].cv = 1'b0;
        if ((run || drain) && m[i].cc < cmax[i])
            m[i].cc++;
        if (kn == rc[i])
            m[i].rl = kn;
        if (run) begin
            if (v && a == 2'd0) begin
                m[i].endk = kn; m[i].code = d[7:0]; m[i].pass = (d[7:0] == 8'd0);
            end else begin
                if (v && a == 2'd1)
                    m[i].rl = kn;
                else if (tc[i] != 0 && kn == m[i].rl + tc[i]) begin
                    m[i].endk = kn; m[i].tout = 1'b1; m[i].code = 8'hFF; m[i].pass = 1'b0;
                end
                if (v && a == 2'd2) begin
                    m[i].cv = 1'b1; m[i].cd = d[7:0];
                end
            end
        end
        m[i].k = kn;
    endtask

    function automatic obs_t expect_of(int i);
        obs_t o;
        o.sr   = (m[i].k < rc[i]);
        o.rdy  = in_run(i);
        o.cv   = m[i].cv;
        o.cd   = m[i].cd;
        o.done = in_done(i);
        o.pass = m[i].pass;
        o.code = m[i].code;
        o.tout = m[i].tout;
        o.cc   = 32'(m[i].cc);
        return o;
    endfunction

    task automatic check_obs(int i, obs_t got, obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 20)
                $display("FAIL dut%0d outputs t=%0t got sr=%0b rdy=%0b cv=%0b cd=%h done=%0b pass=%0b code=%h tout=%0b cc=%0d want sr=%0b rdy=%0b cv=%0b cd=%h done=%0b pass=%0b code=%h tout=%0b cc=%0d",
                         i, $time, got.sr, got.rdy, got.cv, got.cd, got.done, got.pass, got.code, got.tout, got.cc,
                         want.sr, want.rdy, want.cv, want.cd, want.done, want.pass, want.code, want.tout, want.cc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q0.size() > 0) check_obs(0, obs_a, exp_q0.pop_front());
        if (exp_q1.size() > 0) check_obs(1, obs_b, exp_q1.pop_front());
    end

    task automatic step(logic r, logic v, logic [1:0] a, logic [31:0] d);
        reset = r; wr_valid = v; wr_addr = a; wr_data = d;
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i, r, v, a, d);
        exp_q0.push_back(expect_of(0));
        exp_q1.push_back(expect_of(1));
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    // Idle until the next edge would be dut0's watchdog expiry.
    task automatic wait_expiry();
        int n;
        n = 0;
        while (!(in_run(0) && m[0].k + 1 == m[0].rl + tc[0]) && n < 400) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL expiry_wait got %0d cycles without reaching expiry, required fewer than 400", n);
        end
    endtask

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        int          x;

        repeat (2) step(1'b1, 1'b0, 2'd0, 32'd0);

        // Hold stretch, back-to-back characters, periodic kicks, clean exit.
        idle(16);
        step(1'b0, 1'b1, 2'd2, 32'h0000_0048);
        step(1'b0, 1'b1, 2'd2, 32'h0000_0069);
        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 0) step(1'b0, 1'b1, 2'd1, $urandom);
            else step(1'b0, 1'($urandom_range(0, 1)), 2'(2 + $urandom_range(0, 1)), $urandom);
        end
        step(1'b0, 1'b1, 2'd0, 32'h0000_0000);
        repeat (12) step(1'b0, 1'b1, 2'd0, 32'h0000_0005);

        // Reset in DONE, then let the watchdog expire; dut1 saturates cycle_count.
        step(1'b1, 1'b0, 2'd0, 32'd0);
        idle(400);
        step(1'b0, 1'b1, 2'd0, 32'h0000_0003);
        idle(3);

        // Reset mid-RUN, KICK on the expiry edge, then EXIT on the expiry edge.
        step(1'b1, 1'b0, 2'd0, 32'd0);
        idle(30);
        step(1'b1, 1'b0, 2'd0, 32'd0);
        idle(16);
        wait_expiry();
        step(1'b0, 1'b1, 2'd1, 32'd0);
        wait_expiry();
        step(1'b0, 1'b1, 2'd0, 32'h0000_0007);
        idle(12);

        // wr_valid held through HOLD must not be taken until RUN.
        step(1'b1, 1'b0, 2'd0, 32'd0);
        repeat (20) step(1'b0, 1'b1, 2'd0, 32'h0000_0009);
        idle(12);

        // Random traffic with occasional resets.
        step(1'b1, 1'b0, 2'd0, 32'd0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0 || (in_done(0) && in_done(1))) begin
                step(1'b1, 1'b0, 2'd0, 32'd0);
            end else begin
                x = $urandom_range(0, 99);
                a = (x < 2) ? 2'd0 : (x < 20) ? 2'd1 : (x < 70) ? 2'd2 : 2'd3;
                d = $urandom;
                if (a == 2'd0 && $urandom_range(0, 1) == 0) d = 32'h0000_0100;
                step(1'b0, 1'($urandom_range(0, 2) != 0), a, d);
            end
        end

        // Long idle run: dut1 has the watchdog disabled.
        step(1'b1, 1'b0, 2'd0, 32'd0);
        idle(10000);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
